// File: rtl/as_gpio_bridge.sv
// as_gpio_bridge: memory-mapped GPIO output bridge.
// Core stores that hit the GPIO window are queued in a small FIFO and replayed
// one at a time as single-cycle cs_o strobes, with at least CS_GAP idle cycles
// between strobes. Loads in the window return the last emitted value plus the
// queue occupancy.
// Optional build macro AS_GPIO_DROP_EN: stores arriving while the FIFO is full
// are acked and discarded instead of stalling, and a sticky overflow flag is kept.
module as_gpio_bridge #(
  parameter int unsigned NR_GPIOS    = 8,
  parameter int unsigned GPIO_ADDR_W = 8,
  parameter logic [31:0] GPIO_BASE   = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CS_GAP      = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stb_i,
  input  logic                   we_i,
  input  logic [31:0]            addr_i,
  input  logic [63:0]            wdata_i,
  output logic [63:0]            rdata_o,
  output logic                   ack_o,
  output logic [NR_GPIOS-1:0]    gpio_o,
  output logic [GPIO_ADDR_W-1:0] gpioAddr_o,
  output logic                   cs_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  // Gap counter only ever holds values up to CS_GAP-1.
  localparam int unsigned GapW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StStrobe = 2'd1;
  localparam logic [1:0] StGap    = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [GapW-1:0]        gap_q, gap_d;
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        count_q, count_d;
  logic [GPIO_ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [NR_GPIOS-1:0]    fifo_data_q [FIFO_DEPTH];
  logic [NR_GPIOS-1:0]    gpio_q;
  logic [GPIO_ADDR_W-1:0] gpio_addr_q;
  logic                   cs_q;
  logic                   ack_q;
  logic [63:0]            rdata_q, rdata_d;

  logic                   hit, full, store_req, load_req, push, pop, accept;
  logic [63:0]            wdata_shift;
  logic [NR_GPIOS-1:0]    push_data;
  logic                   ovf_flag;
  logic                   unused_shift;

  // Address decode, store lane extraction and handshake qualification.
  always_comb begin
    hit         = (addr_i[31:GPIO_ADDR_W] == GPIO_BASE[31:GPIO_ADDR_W]);
    // Full is judged on the registered count, so a pop in this cycle never
    // makes room for a push in the same cycle.
    full        = (count_q == CntW'(FIFO_DEPTH));
    store_req   = stb_i & we_i & hit;
    load_req    = stb_i & ~we_i & hit;
    push        = store_req & ~full;
    pop         = (state_q == StIdle) && (count_q != '0);
    wdata_shift = wdata_i >> {addr_i[2:0], 3'b000};
    push_data   = wdata_shift[NR_GPIOS-1:0];
`ifdef AS_GPIO_DROP_EN
    accept      = load_req | store_req;
`else
    accept      = load_req | push;
`endif
  end

  assign unused_shift = ^wdata_shift[63:NR_GPIOS];

`ifdef AS_GPIO_DROP_EN
  logic ovf_q;

  // Sticky overflow: set by any store that finds the queue full.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ovf_q <= 1'b0;
    end else if (store_req && full) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_flag = ovf_q;
`else
  assign ovf_flag = 1'b0;
`endif

  // Occupancy next state; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Drain FSM next state: strobe, then CS_GAP forced-idle cycles before the next pop.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      StIdle: begin
        if (count_q != '0) state_d = StStrobe;
      end
      StStrobe: begin
        if (CS_GAP > 1) begin
          state_d = StGap;
          gap_d   = GapW'(CS_GAP - 1);
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        // Leaving on the last decrement makes the strobe period CS_GAP+1.
        if (gap_q <= GapW'(1)) begin
          state_d = StIdle;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Load response word: occupancy, overflow flag and last emitted data.
  always_comb begin
    rdata_d                 = '0;
    rdata_d[NR_GPIOS-1:0]   = gpio_q;
    rdata_d[55]             = ovf_flag;
    rdata_d[63:56]          = 8'(count_q);
  end

  // Queue storage; only the pointers need clearing on reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= addr_i[GPIO_ADDR_W-1:0];
      fifo_data_q[wr_ptr_q] <= push_data;
    end
  end

  // Control state, pointers and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      gap_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      gpio_q      <= '0;
      gpio_addr_q <= '0;
      cs_q        <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      count_q  <= count_d;
      cs_q     <= pop;
      ack_q    <= accept;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + PtrW'(1);
        gpio_q      <= fifo_data_q[rd_ptr_q];
        gpio_addr_q <= fifo_addr_q[rd_ptr_q];
      end
      if (load_req) rdata_q <= rdata_d;
    end
  end

  assign rdata_o    = rdata_q;
  assign ack_o      = ack_q;
  assign gpio_o     = gpio_q;
  assign gpioAddr_o = gpio_addr_q;
  assign cs_o       = cs_q;

endmodule

// File: tb/tb_as_gpio_bridge.sv
// Self-checking bench for as_gpio_bridge: a table of directed vectors, a few
// hand-written multi-cycle sequences and a randomized phase, all compared
// against a queue-based reference model of the bridge.
module tb_as_gpio_bridge;

  localparam int DEPTH = 4;
  localparam int GAP   = 1;
`ifdef AS_GPIO_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, stb, we;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        ack, cs;
  logic [7:0]  gpio, gaddr;

  always #5 clk = ~clk;

  as_gpio_bridge #(
    .NR_GPIOS   (8),
    .GPIO_ADDR_W(8),
    .GPIO_BASE  (32'h0000_1000),
    .FIFO_DEPTH (DEPTH),
    .CS_GAP     (GAP)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .stb_i     (stb),
    .we_i      (we),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .ack_o     (ack),
    .gpio_o    (gpio),
    .gpioAddr_o(gaddr),
    .cs_o      (cs)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: a queue of pending stores and the edge of the last pop.
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } ent_t;

  ent_t        mq[$];
  int          last_pop = -100;
  logic        m_ack = 1'b0, m_cs = 1'b0, m_ovf = 1'b0, m_load = 1'b0;
  logic [7:0]  m_gpio = 8'h0, m_gaddr = 8'h0;
  logic [63:0] m_rdata = 64'h0;

  logic [7:0]  pulses[$];
  int          pulse_cyc[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    int          pre;
    bit          hit, pop_now, do_push;
    ent_t        e;
    logic [63:0] sh;
    m_load = 1'b0;
    m_ack  = 1'b0;
    if (!rst_n) begin
      mq.delete();
      m_cs     = 1'b0;
      m_gpio   = 8'h0;
      m_gaddr  = 8'h0;
      m_rdata  = 64'h0;
      m_ovf    = 1'b0;
      last_pop = -100;
      return;
    end
    pre     = mq.size();
    hit     = (addr[31:8] == 24'h000010);
    pop_now = (pre > 0) && ((cyc - last_pop) >= GAP + 1);
    do_push = 1'b0;
    if (stb && hit && !we) begin
      m_ack   = 1'b1;
      m_load  = 1'b1;
      m_rdata = {8'(pre), m_ovf, 47'b0, m_gpio};
    end
    if (stb && hit && we) begin
      if (pre < DEPTH) begin
        m_ack   = 1'b1;
        do_push = 1'b1;
      end else if (DROP) begin
        m_ack = 1'b1;
        m_ovf = 1'b1;
      end
    end
    if (pop_now) begin
      e        = mq.pop_front();
      m_gpio   = e.d;
      m_gaddr  = e.a;
      m_cs     = 1'b1;
      last_pop = cyc;
    end else begin
      m_cs = 1'b0;
    end
    if (do_push) begin
      sh = wdata >> (8 * addr[2:0]);
      mq.push_back({addr[7:0], sh[7:0]});
    end
  endtask

  // One clock: advance the model at the edge, compare just after it.
  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("ack", {63'b0, ack}, {63'b0, m_ack});
    chk("cs", {63'b0, cs}, {63'b0, m_cs});
    chk("gpio", {56'b0, gpio}, {56'b0, m_gpio});
    chk("gpio_addr", {56'b0, gaddr}, {56'b0, m_gaddr});
    if (m_load) chk("rdata", rdata, m_rdata);
    if (cs) begin
      pulses.push_back(gpio);
      pulse_cyc.push_back(cyc);
    end
  endtask

  task automatic idle(input int n);
    stb = 1'b0;
    we  = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Hit store, held until the model says it was accepted (bounded).
  task automatic store(input logic [31:0] a, input logic [63:0] d, output int stalls);
    bit done = 1'b0;
    stalls = 0;
    stb    = 1'b1;
    we     = 1'b1;
    addr   = a;
    wdata  = d;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (m_ack) done = 1'b1;
      else stalls++;
    end
    if (!done) begin
      failures++;
      $display("FAIL store_timeout cyc=%0d got=no_accept exp=accept", cyc);
    end
  endtask

  task automatic load(input logic [31:0] a);
    stb  = 1'b1;
    we   = 1'b0;
    addr = a;
    step();
    stb  = 1'b0;
  endtask

  typedef struct {
    bit          rst_n;
    bit          stb;
    bit          we;
    logic [31:0] addr;
    logic [63:0] wdata;
    bit          ack;
    bit          cs;
    logic [7:0]  gpio;
    logic [7:0]  gaddr;
    bit          chk_rd;
    logic [63:0] rdata;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int st, tot;
    // Single store, hold, miss, lane-0 store and a load.
    vecs[0] = '{1, 1, 1, 32'h1004, 64'h0000_0001_0000_0000, 1, 0, 8'h00, 8'h00, 0, 64'h0};
    vecs[1] = '{1, 0, 0, 32'h0000, 64'h0, 0, 1, 8'h01, 8'h04, 0, 64'h0};
    vecs[2] = '{1, 0, 0, 32'h0000, 64'h0, 0, 0, 8'h01, 8'h04, 0, 64'h0};
    vecs[3] = '{1, 1, 1, 32'h2004, 64'h0000_0033_0000_0000, 0, 0, 8'h01, 8'h04, 0, 64'h0};
    vecs[4] = '{1, 0, 0, 32'h0000, 64'h0, 0, 0, 8'h01, 8'h04, 0, 64'h0};
    vecs[5] = '{1, 1, 1, 32'h1000, 64'h1122_3344_5566_77A5, 1, 0, 8'h01, 8'h04, 0, 64'h0};
    vecs[6] = '{1, 0, 0, 32'h0000, 64'h0, 0, 1, 8'hA5, 8'h00, 0, 64'h0};
    vecs[7] = '{1, 0, 0, 32'h0000, 64'h0, 0, 0, 8'hA5, 8'h00, 0, 64'h0};
    vecs[8] = '{1, 1, 0, 32'h1000, 64'h0, 1, 0, 8'hA5, 8'h00, 1, 64'h0000_0000_0000_00A5};
    vecs[9] = '{1, 0, 0, 32'h0000, 64'h0, 0, 0, 8'hA5, 8'h00, 0, 64'h0};

    rst_n = 1'b0;
    stb   = 1'b0;
    we    = 1'b0;
    addr  = 32'h0;
    wdata = 64'h0;
    step();
    step();
    chk("reset_cs", {63'b0, cs}, 64'h0);
    chk("reset_ack", {63'b0, ack}, 64'h0);
    chk("reset_gpio", {56'b0, gpio}, 64'h0);
    chk("reset_gpio_addr", {56'b0, gaddr}, 64'h0);
    rst_n = 1'b1;
    idle(2);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n;
      stb   = vecs[i].stb;
      we    = vecs[i].we;
      addr  = vecs[i].addr;
      wdata = vecs[i].wdata;
      step();
      chk("tbl_ack", {63'b0, ack}, {63'b0, vecs[i].ack});
      chk("tbl_cs", {63'b0, cs}, {63'b0, vecs[i].cs});
      chk("tbl_gpio", {56'b0, gpio}, {56'b0, vecs[i].gpio});
      chk("tbl_gpio_addr", {56'b0, gaddr}, {56'b0, vecs[i].gaddr});
      if (vecs[i].chk_rd) chk("tbl_rdata", rdata, vecs[i].rdata);
    end
    idle(2);

    // Back-to-back stores 1,3,5,7: four pulses, CS_GAP+1 apart, no stall.
    pulses.delete();
    pulse_cyc.delete();
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      store(32'h1004, 64'(2 * i + 1) << 32, st);
      tot += st;
    end
    idle(12);
    chk("b2b_stalls", 64'(tot), 64'h0);
    chk("b2b_npulses", 64'(pulses.size()), 64'd4);
    if (pulses.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("b2b_value", {56'b0, pulses[i]}, 64'(2 * i + 1));
      for (int i = 0; i < 3; i++)
        chk("b2b_spacing", 64'(pulse_cyc[i+1] - pulse_cyc[i]), 64'(GAP + 1));
    end

    // Fill while draining: FIFO reaches full, later stores stall (or drop).
    pulses.delete();
    tot = 0;
    for (int i = 0; i < 10; i++) begin
      store(32'h1010, 64'(8'h10 + i), st);
      tot += st;
    end
    load(32'h1000);
    chk("fill_ovf_bit", {63'b0, rdata[55]}, {63'b0, DROP});
    idle(30);
    if (DROP) begin
      chk("fill_stalls", 64'(tot), 64'h0);
      chk("fill_dropped", 64'(pulses.size() < 10), 64'h1);
    end else begin
      chk("fill_stalled", 64'(tot > 0), 64'h1);
      chk("fill_npulses", 64'(pulses.size()), 64'd10);
      if (pulses.size() == 10)
        for (int i = 0; i < 10; i++) chk("fill_order", {56'b0, pulses[i]}, 64'(8'h10 + i));
    end

    // Load after emitting 0x07 with two entries queued.
    store(32'h1000, 64'h07, st);
    store(32'h1000, 64'h0A, st);
    store(32'h1000, 64'h0B, st);
    load(32'h1000);
    chk("load_ack", {63'b0, ack}, 64'h1);
    chk("load_rdata", rdata, {8'd2, DROP, 47'b0, 8'h07});
    idle(10);

    // Reset while strobing with three entries queued.
    for (int i = 0; i < 6; i++) store(32'h1008, 64'(8'h20 + i), st);
    chk("pre_rst_cs", {63'b0, cs}, 64'h1);
    stb   = 1'b0;
    rst_n = 1'b0;
    step();
    chk("rst_cs", {63'b0, cs}, 64'h0);
    rst_n = 1'b1;
    pulses.delete();
    idle(10);
    chk("rst_no_pulses", 64'(pulses.size()), 64'h0);
    load(32'h1000);
    chk("rst_rdata", rdata, 64'h0);
    idle(2);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      int op;
      op = $urandom_range(0, 99);
      if (op < 1) begin
        stb   = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else if (op < 40) begin
        idle(1);
      end else if (op < 75) begin
        store(32'h1000 | 32'($urandom_range(0, 255)), {$urandom, $urandom}, st);
      end else if (op < 85) begin
        stb   = 1'b1;
        we    = 1'b1;
        addr  = 32'h2000 | 32'($urandom_range(0, 255));
        wdata = {$urandom, $urandom};
        step();
        stb   = 1'b0;
      end else begin
        load(32'h1000 | 32'($urandom_range(0, 255)));
      end
    end
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
